// File: rtl/fp_sum_sequencer_pkg.sv
// Shared types and constants for the floating-point sum sequencer and its adder interface.
// State encoding, IEEE-754 single-precision field widths and adder opcodes.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } seq_state_e;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;

  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_SUB = 1'b1;

endpackage

// File: rtl/fp_sum_sequencer_if.sv
// Bundle of the operand stream, adder control and sum output channels of the sequencer.
// The master modport is the sequencer side; the slave modport is the surrounding environment.
interface fp_sum_sequencer_if #(
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;

  logic             fpu_start;
  logic             fpu_op;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_ready;
  logic             fpu_busy;
  logic [31:0]      fpu_y;

  logic             sum_valid;
  logic             sum_ready;
  logic [31:0]      sum_data;
  logic [CNT_W-1:0] sum_count;

  modport master (
    input  in_valid, in_data, in_sub, in_last,
    input  fpu_ready, fpu_busy, fpu_y,
    input  sum_ready,
    output in_ready,
    output fpu_start, fpu_op, fpu_a, fpu_b,
    output sum_valid, sum_data, sum_count
  );

  modport slave (
    output in_valid, in_data, in_sub, in_last,
    output fpu_ready, fpu_busy, fpu_y,
    output sum_ready,
    input  in_ready,
    input  fpu_start, fpu_op, fpu_a, fpu_b,
    input  sum_valid, sum_data, sum_count
  );

endinterface

// File: rtl/fp_sum_sequencer_watchdog.sv
// Cycle counter that flags an adder operation that has been outstanding for TIMEOUT_CYCLES.
// Only instantiated by fp_sum_sequencer when FP_SEQ_TIMEOUT_EN is defined.
module fp_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts cycles spent enabled; expiry is reported on the final cycle so the
  // owner acts on the edge that completes TIMEOUT_CYCLES cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/fp_sum_sequencer.sv
// Streams operands through the multi-cycle adder_fp and presents the running sum on the last element.
// Optional adder timeout with sticky err flag is enabled by defining FP_SEQ_TIMEOUT_EN.
module fp_sum_sequencer
  import fp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_sum_sequencer_if.master  bus,
  output logic                err
);

  seq_state_e       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      b_q, b_d;
  logic             sub_q, sub_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             wd_expired;

`ifdef FP_SEQ_TIMEOUT_EN
  logic err_q, err_d;

  fp_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q == WAIT),
    .clr_i     (state_q != WAIT),
    .expired_o (wd_expired)
  );

  // A ready arriving on the expiry cycle wins; only a genuine timeout sets the flag.
  always_comb begin
    err_d = err_q;
    if ((state_q == WAIT) && !bus.fpu_ready && wd_expired) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sub_d   = sub_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          b_d     = bus.in_data;
          sub_d   = bus.in_sub;
          last_d  = bus.in_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.fpu_ready) begin
          acc_d = bus.fpu_y;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = last_q ? EMIT : IDLE;
        end else if (wd_expired) begin
          state_d = last_q ? EMIT : IDLE;
        end
      end
      EMIT: begin
        if (bus.sum_ready) begin
          acc_d   = FP_POS_ZERO;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= FP_POS_ZERO;
      b_q     <= '0;
      sub_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready also watches fpu_busy because the adder is not reset with us.
  assign bus.in_ready  = (state_q == IDLE) && !bus.fpu_busy;
  assign bus.fpu_start = (state_q == ISSUE);
  assign bus.fpu_op    = sub_q ? FP_OP_SUB : FP_OP_ADD;
  assign bus.fpu_a     = acc_q;
  assign bus.fpu_b     = b_q;
  assign bus.sum_valid = (state_q == EMIT);
  assign bus.sum_data  = acc_q;
  assign bus.sum_count = cnt_q;

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// Self-checking bench for fp_sum_sequencer with a behavioural adder_fp stub and a real-arithmetic sum model.
// The timeout section runs only when FP_SEQ_TIMEOUT_EN is defined.
module tb_fp_sum_sequencer;
  import fp_pkg::*;

  localparam int CNT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  int checks = 0;
  int errors = 0;

  fp_sum_sequencer_if #(.CNT_W(CNT_W)) bus();

  logic        stubReady  = 1'b0;
  logic        stubBusy   = 1'b0;
  logic [31:0] stubY      = 32'h0;
  logic [31:0] capA       = 32'h0;
  logic [31:0] capB       = 32'h0;
  logic        capOp      = 1'b0;
  int          stubPhase  = 0;
  int          stubLeft   = 0;
  int          stubLat    = 1;
  int          startCount = 0;
  int          holdErrs   = 0;
  bit          noReady    = 1'b0;

  real expSum   = 0.0;
  int  expCount = 0;

  assign bus.fpu_ready = stubReady;
  assign bus.fpu_busy  = stubBusy;
  assign bus.fpu_y     = stubY;

  fp_sum_sequencer #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Single-precision <-> real conversion for normal numbers, zero and specials.
  function automatic real s2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    if (f[30:23] == 8'hFF) e = 11'h7FF;
    else e = 11'(f[30:23]) - 11'd127 + 11'd1023;
    d = {f[31], e, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [7:0]  e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) e = 8'hFF;
    else e = 8'(d[62:52] - 11'd1023 + 11'd127);
    return {d[63], e, d[51:29]};
  endfunction

  function automatic bit isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (isNan(a)) return a | 32'h0040_0000;
    if (isNan(b)) return b | 32'h0040_0000;
    return r2s(op ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b)));
  endfunction

  // Adder stub: samples start, answers after stubLat cycles, then stays busy one more cycle.
  always @(negedge clk) begin
    if (bus.fpu_start) startCount <= startCount + 1;
    case (stubPhase)
      0: begin
        if (bus.fpu_start && !noReady) begin
          capA      <= bus.fpu_a;
          capB      <= bus.fpu_b;
          capOp     <= bus.fpu_op;
          stubBusy  <= 1'b1;
          stubLeft  <= stubLat;
          stubPhase <= 1;
        end
      end
      1: begin
        if (stubLeft <= 1) begin
          stubReady <= 1'b1;
          stubY     <= fpAdd(capA, capB, capOp);
          if (bus.fpu_a !== capA || bus.fpu_b !== capB || bus.fpu_op !== capOp)
            holdErrs <= holdErrs + 1;
          stubPhase <= 2;
        end else begin
          stubLeft <= stubLeft - 1;
        end
      end
      2: begin
        stubReady <= 1'b0;
        stubPhase <= 3;
      end
      default: begin
        stubBusy  <= 1'b0;
        stubPhase <= 0;
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one operand and returns on the tick after the accept edge.
  task automatic applyStimulus(input logic [31:0] data, input logic sub, input logic last, input int lat);
    bit taken;
    taken       = 1'b0;
    stubLat     = lat;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sub   = sub;
    bus.in_last  = last;
    for (int i = 0; i < 100 && !taken; i++) begin
      @(negedge clk);
      #1;
      taken = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_sub   = 1'b0;
    bus.in_last  = 1'b0;
    checkOutput("accept", 64'(taken), 64'd1);
  endtask

  task automatic sendAndModel(input int v, input bit sub, input bit last, input int lat);
    applyStimulus(r2s($itor(v)), sub, last, lat);
    expSum = sub ? (expSum - $itor(v)) : (expSum + $itor(v));
    expCount++;
  endtask

  task automatic waitSum();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.sum_valid) seen = 1'b1;
      else tick();
    end
    checkOutput("sum_valid_seen", 64'(seen), 64'd1);
  endtask

  task automatic checkSum(input string tag);
    waitSum();
    checkOutput({tag, "_data"}, 64'(bus.sum_data), 64'(r2s(expSum)));
    checkOutput({tag, "_count"}, 64'(bus.sum_count), 64'(expCount));
  endtask

  task automatic takeSum();
    bus.sum_ready = 1'b1;
    tick();
    bus.sum_ready = 1'b0;
    expSum   = 0.0;
    expCount = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int s0;
    int len;
    int v;
    bit sb;
    int early;
    int violations;
    bit busyCleared;
    logic [FP_EXP_W-1:0] nanExp;

    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_sub    = 1'b0;
    bus.in_last   = 1'b0;
    bus.sum_ready = 1'b0;

    // Reset values
    tick();
    tick();
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_fpu_start", 64'(bus.fpu_start), 64'd0);
    checkOutput("rst_sum_valid", 64'(bus.sum_valid), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_fpu_a", 64'(bus.fpu_a), 64'd0);
    checkOutput("rst_sum_count", 64'(bus.sum_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1.0 + 2.0
    s0 = startCount;
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0, 2);
    checkOutput("start_high", 64'(bus.fpu_start), 64'd1);
    tick();
    checkOutput("start_low", 64'(bus.fpu_start), 64'd0);
    applyStimulus(32'h4000_0000, 1'b0, 1'b1, 3);
    waitSum();
    checkOutput("two_sum_data", 64'(bus.sum_data), 64'h4040_0000);
    checkOutput("two_sum_count", 64'(bus.sum_count), 64'd2);
    checkOutput("two_start_pulses", 64'(startCount - s0), 64'd2);
    takeSum();

    // 5.0 - 2.0
    applyStimulus(32'h40A0_0000, 1'b0, 1'b0, 1);
    applyStimulus(32'h4000_0000, 1'b1, 1'b1, 2);
    waitSum();
    checkOutput("sub_sum_data", 64'(bus.sum_data), 64'h4040_0000);
    takeSum();

    // Backpressure with a pending operand, then a fresh sum from zero
    sendAndModel(7, 1'b0, 1'b0, 2);
    sendAndModel(2, 1'b1, 1'b1, 1);
    waitSum();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F80_0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_sum_data", 64'(bus.sum_data), 64'h40A0_0000);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_sum_valid", 64'(bus.sum_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    takeSum();
    sendAndModel(9, 1'b0, 1'b1, 2);
    checkSum("after_bp");
    takeSum();

    // Single subtracted element: 0 - 6
    sendAndModel(6, 1'b1, 1'b1, 3);
    checkSum("single_sub");
    takeSum();

    // Randomized sums
    for (int s = 0; s < 5; s++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        v  = int'($urandom_range(0, 100)) - 50;
        sb = 1'($urandom_range(0, 1));
        sendAndModel(v, sb, (k == len - 1), int'($urandom_range(1, 4)));
      end
      checkSum("rand");
      takeSum();
    end

    checkOutput("operand_hold", 64'(holdErrs), 64'd0);

    // Reset pulsed in WAIT while the adder is busy
    applyStimulus(r2s(4.0), 1'b0, 1'b0, 1);
    applyStimulus(r2s(10.0), 1'b0, 1'b0, 8);
    tick();
    checkOutput("wait_fpu_a", 64'(bus.fpu_a), 64'(r2s(4.0)));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_fpu_start", 64'(bus.fpu_start), 64'd0);
    checkOutput("midrst_sum_valid", 64'(bus.sum_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("midrst_fpu_a", 64'(bus.fpu_a), 64'd0);
    checkOutput("midrst_sum_count", 64'(bus.sum_count), 64'd0);
    tick();
    rst_n = 1'b1;
    violations  = 0;
    busyCleared = 1'b0;
    for (int i = 0; i < 40 && !busyCleared; i++) begin
      if (stubBusy) begin
        if (bus.in_ready) violations++;
      end else begin
        busyCleared = 1'b1;
      end
      if (!busyCleared) tick();
    end
    checkOutput("midrst_busy_clear", 64'(busyCleared), 64'd1);
    checkOutput("midrst_ready_while_busy", 64'(violations), 64'd0);
    checkOutput("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);
    checkOutput("midrst_late_ready_acc", 64'(bus.fpu_a), 64'd0);
    expSum   = 0.0;
    expCount = 0;
    sendAndModel(3, 1'b1, 1'b1, 2);
    checkSum("post_rst");
    takeSum();

    // NaN propagation
    applyStimulus(32'h7F80_0001, 1'b0, 1'b0, 1);
    applyStimulus(32'h3F80_0000, 1'b0, 1'b1, 2);
    waitSum();
    nanExp = bus.sum_data[FP_MAN_W +: FP_EXP_W];
    checkOutput("nan_exp", 64'(nanExp), 64'hFF);
    checkOutput("nan_man_nonzero", 64'(|bus.sum_data[FP_MAN_W-1:0]), 64'd1);
    checkOutput("nan_count", 64'(bus.sum_count), 64'd2);
    takeSum();

`ifdef FP_SEQ_TIMEOUT_EN
    // Adder never answers: element dropped after eight WAIT cycles
    sendAndModel(2, 1'b0, 1'b0, 1);
    noReady = 1'b1;
    applyStimulus(r2s(50.0), 1'b0, 1'b0, 1);
    tick();
    early = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (err) early++;
    end
    tick();
    checkOutput("to_err_early", 64'(early), 64'd0);
    checkOutput("to_err", 64'(err), 64'd1);
    checkOutput("to_idle_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("to_acc_kept", 64'(bus.fpu_a), 64'(r2s(2.0)));
    noReady = 1'b0;
    sendAndModel(1, 1'b0, 1'b1, 1);
    checkSum("to_sum");
    checkOutput("to_err_sticky", 64'(err), 64'd1);
    takeSum();
`else
    early = 0;
    checkOutput("err_tied_low", 64'(err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
